// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the RV32M multiply/divide sequencer.
//   mdop_t      - M-extension operation, encoded in funct3 order
//   mdu_state_t - sequencer FSM states
//   is_div / is_signed_a / is_signed_b - operation classification helpers
package mdu_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } mdop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   function automatic logic is_div(input mdop_t op);
      return op[2];
   endfunction

   // MUL low word is sign-agnostic, so it runs unsigned.
   function automatic logic is_signed_a(input mdop_t op);
      return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_signed_b(input mdop_t op);
      return (op == MULH) || (op == DIV) || (op == REM);
   endfunction

endpackage

// File: rtl/mdu_ctrl_core.sv
// mdu_core: iterative radix-2 multiply/divide datapath.
//   clk, rst      - clock, async active-high reset
//   load          - capture op, operand magnitudes and sign flags
//   step          - perform one shift-add / restoring-divide iteration
//   finish        - register the sign-fixed result (uses this cycle's step)
//   mdop, opr_a, opr_b - operation and raw operands (sampled on load)
//   special       - combinational: current inputs are divide-by-zero or MIN/-1
//   result        - registered final result, held until the next finish
module mdu_core
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic                  finish,
   input  mdop_t                 mdop,
   input  logic [DATA_WIDTH-1:0] opr_a,
   input  logic [DATA_WIDTH-1:0] opr_b,
   output logic                  special,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int W = DATA_WIDTH;

   logic          sa_in, sb_in, div0_in, ovf_in;
   logic [W-1:0]  ma_in, mb_in;

   mdop_t         op_q;
   logic          sa_q, sb_q, div0_q, ovf_q;
   logic [2*W-1:0] acc_q, acc_nxt, prod;
   logic [W-1:0]  b_q, quo, rmd, res_nxt;
   logic [W:0]    add_sum, sub_cand, sub_diff;

   always_comb begin
      sa_in   = is_signed_a(mdop) & opr_a[W-1];
      sb_in   = is_signed_b(mdop) & opr_b[W-1];
      ma_in   = sa_in ? -opr_a : opr_a;
      mb_in   = sb_in ? -opr_b : opr_b;
      div0_in = is_div(mdop) && (opr_b == '0);
      ovf_in  = is_div(mdop) && is_signed_b(mdop) &&
                (opr_a == {1'b1, {(W-1){1'b0}}}) && (opr_b == '1);
   end

   assign special = div0_in | ovf_in;

   // acc holds {hi, lo}. Multiply: lo is the multiplier, shifted out LSB first
   // while hi accumulates. Divide: hi is the partial remainder, lo the
   // dividend shifting in as quotient bits shift in.
   always_comb begin
      add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
      sub_cand = acc_q[2*W-1:W-1];
      sub_diff = sub_cand - {1'b0, b_q};
      acc_nxt  = acc_q;
      if (step && !div0_q && !ovf_q) begin
         if (is_div(op_q))
            acc_nxt = sub_diff[W] ? {sub_cand[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {sub_diff[W-1:0], acc_q[W-2:0], 1'b1};
         else
            acc_nxt = {add_sum, acc_q[W-1:1]};
      end
   end

   // Sign fix-up works on acc_nxt so the final iteration and the fix-up
   // land on the same edge.
   always_comb begin
      prod = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
      quo  = (sa_q ^ sb_q) ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
      rmd  = sa_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
      if (div0_q) begin
         // acc was never stepped: lo still holds |a|, rebuild the original a
         quo = '1;
         rmd = sa_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
      end
      if (ovf_q) begin
         quo = {1'b1, {(W-1){1'b0}}};
         rmd = '0;
      end
      case (op_q)
         MUL:                 res_nxt = prod[W-1:0];
         MULH, MULHSU, MULHU: res_nxt = prod[2*W-1:W];
         DIV, DIVU:           res_nxt = quo;
         default:             res_nxt = rmd;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q   <= MUL;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         div0_q <= 1'b0;
         ovf_q  <= 1'b0;
         acc_q  <= '0;
         b_q    <= '0;
         result <= '0;
      end else begin
         if (load) begin
            op_q   <= mdop;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
            acc_q  <= {{W{1'b0}}, ma_in};
            b_q    <= mb_in;
         end else begin
            acc_q  <= acc_nxt;
         end
         if (finish)
            result <= res_nxt;
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: RV32M multi-cycle sequencer beside the EX-stage ALU.
//   clk, rst  - clock, async active-high reset
//   start     - EX holds an M-op (level, held while stall_o is high)
//   mdop      - M-extension operation
//   opr_a/b   - forwarded rs1/rs2 values
//   flush     - kill the in-flight op
//   stall_o   - freeze IF/ID/EX pipeline registers
//   busy      - engine occupied (state != IDLE)
//   done      - single-cycle result-valid pulse
//   result    - final result, valid while done is high
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  mdop_t                 mdop,
   input  logic [DATA_WIDTH-1:0] opr_a,
   input  logic [DATA_WIDTH-1:0] opr_b,
   input  logic                  flush,
   output logic                  stall_o,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int CW = $clog2(DATA_WIDTH);

   mdu_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load, step, finish, special;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      stall_o = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               load    = 1'b1;
               stall_o = 1'b1;
               state_d = BUSY;
               // Special divides spend a single BUSY cycle (counter 0) in
               // which the core ignores step and only applies the fix-up.
               cnt_d   = special ? '0 : CW'(DATA_WIDTH - 1);
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               stall_o = 1'b1;
               step    = 1'b1;
               if (cnt_q == '0) begin
                  finish  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         DONE: begin
            done    = !flush;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);

   mdu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .finish  (finish),
      .mdop    (mdop),
      .opr_a   (opr_a),
      .opr_b   (opr_b),
      .special (special),
      .result  (result)
   );

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed-vector bench for mdu_ctrl (DATA_WIDTH=32).
module tb_mdu_ctrl;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   mdop_t       mdop;
   logic [31:0] opr_a, opr_b;
   logic        stall_o, busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   mdu_ctrl #(.DATA_WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mdop    (mdop),
      .opr_a   (opr_a),
      .opr_b   (opr_b),
      .flush   (flush),
      .stall_o (stall_o),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   // Raises start just after a posedge (cycle 0) and follows the op to done.
   // Returns at the negedge of the done cycle with start still high; a
   // following run_op therefore issues in the first IDLE cycle after DONE.
   task automatic run_op(input string tag, input mdop_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int  cyc;
      bit  seen;
      bit  stall_ok;
      @(posedge clk); #1;
      start = 1'b1; mdop = op; opr_a = a; opr_b = b;
      cyc = 0; seen = 0; stall_ok = 1;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         if (done) seen = 1;
         else begin
            if (!stall_o) stall_ok = 0;
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk({tag, "_lat"}, cyc, lat);
      chk({tag, "_res"}, result, exp);
      chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
      chk({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; mdop = MUL; opr_a = '0; opr_b = '0;
      #2;
      chk("rst_stall",  {31'd0, stall_o}, 32'd0);
      chk("rst_busy",   {31'd0, busy},    32'd0);
      chk("rst_done",   {31'd0, done},    32'd0);
      chk("rst_result", result,           32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("mul",    MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhu",  MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
      run_op("mulhu2", MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("div",    DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",    REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu",   DIVU,   32'd100,      32'd7,        32'd14,       33);
      run_op("remu",   REMU,   32'd100,      32'd7,        32'd2,        33);
      go_idle();
      run_op("divu0",  DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 2);
      run_op("remu0",  REMU,   32'h1234,     32'd0,        32'h1234,     2);
      run_op("div0s",  DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 2);
      run_op("rem0s",  REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2);
      run_op("divovf", DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      run_op("removf", REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
      go_idle();

      // flush mid-divide: cycle 0 start, cycle 10 flush
      @(posedge clk); #1;
      start = 1'b1; mdop = DIV; opr_a = 32'd1000; opr_b = 32'd3;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'd0, stall_o}, 32'd0);
      chk("flush_done",  {31'd0, done},    32'd0);
      chk("flush_busy",  {31'd0, busy},    32'd1);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("flush_idle", {31'd0, busy}, 32'd0);
      chk("flush_nodone", {31'd0, done}, 32'd0);
      // issue at cycle 12 -> done at cycle 45 (33 after issue)
      run_op("mul_after_flush", MUL, 32'd12345, 32'd678, 32'd8369910, 33);
      go_idle();

      // asynchronous reset mid-BUSY
      @(posedge clk); #1;
      start = 1'b1; mdop = DIVU; opr_a = 32'd99; opr_b = 32'd5;
      repeat (15) @(posedge clk);
      #3 rst = 1'b1; start = 1'b0;
      #1;
      chk("arst_stall",  {31'd0, stall_o}, 32'd0);
      chk("arst_busy",   {31'd0, busy},    32'd0);
      chk("arst_done",   {31'd0, done},    32'd0);
      chk("arst_result", result,           32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("divu_after_rst", DIVU, 32'd99, 32'd5, 32'd19, 33);
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
